lut_config_sequencer: RTL
=========================

LUT_CONFIG_SEQUENCER -- requirements
Module: lut_config_sequencer

Interface
REQ-001 SHALL have parameter POWERUP_CYCLES, default 20'd1000000, meaning idle cycles after reset or reinit before the first fetch.
REQ-002 SHALL have parameter RESET_DELAY_INDEX, default 10'd1, meaning the LUT index after whose successful write a settle delay is inserted.
REQ-003 SHALL have parameter RESET_DELAY_CYCLES, default 20'd250000, meaning the settle delay length in clk cycles.
REQ-004 SHALL have parameter MAX_RETRY, default 2'd3, meaning the number of retries allowed per entry after a NACK.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-007 SHALL have port reinit, input, 1, a one-cycle pulse that restarts the sequence; honoured only in DONE or ERROR.
REQ-008 SHALL have port lut_index, output, 10, the LUT address being fetched.
REQ-009 SHALL have port lut_data, input, 32, from the LUT: [31:24] device address, [23:8] register address, [7:0] data.
REQ-010 SHALL have port i2c_slave_dev_addr, output, 8, the registered device address.
REQ-011 SHALL have port i2c_register_addr, output, 16, the registered register address.
REQ-012 SHALL have port i2c_write_data, output, 8, the registered write data.
REQ-013 SHALL have port i2c_write_req, output, 1, the write request; held high until acknowledged.
REQ-014 SHALL have port i2c_write_req_ack, input, 1, a one-cycle pulse from the I2C master marking transaction end.
REQ-015 SHALL have port i2c_error, input, 1, the NACK flag; valid in the cycle i2c_write_req_ack is high.
REQ-016 SHALL have port done, output, 1, high (level) once the sequence completes.
REQ-017 SHALL have port error, output, 1, high (level) once retries are exhausted.

Function
REQ-018 SHALL implement states PWRUP, FETCH, REQ, WAIT_ACK, DELAY, DONE, ERROR.
REQ-019 SHALL wait POWERUP_CYCLES cycles in PWRUP (count 0..POWERUP_CYCLES-1), then go to FETCH.
REQ-020 SHALL, in FETCH (one cycle), register lut_data fields into the three i2c_* outputs, clear the retry counter, and select the next state:
- lut_data[31:24]==8'hFF -> DONE
- otherwise -> REQ
REQ-021 SHALL drive i2c_write_req high in REQ and WAIT_ACK (REQ lasts one cycle), clearing it in the cycle after ack is sampled.
REQ-022 SHALL, on i2c_write_req_ack=1 in WAIT_ACK:
- i2c_error=0 -> DELAY if lut_index==RESET_DELAY_INDEX; else advance (REQ-023)
- i2c_error=1 and retry<MAX_RETRY -> retry+1, REQ with the same entry
- i2c_error=1 and retry==MAX_RETRY -> ERROR
REQ-023 SHALL advance by incrementing lut_index and going to FETCH; if lut_index==10'd1023 it SHALL go to DONE without wrapping.
REQ-024 SHALL count RESET_DELAY_CYCLES in DELAY, then advance (REQ-023).
REQ-025 SHALL hold done=1 in DONE and error=1 in ERROR; both are mutually exclusive and 0 in every other state.
REQ-026 SHALL, on reinit in DONE or ERROR, clear done/error and lut_index and re-enter PWRUP; it SHALL ignore reinit in all other states.
REQ-027 SHALL ignore i2c_write_req_ack outside WAIT_ACK.
REQ-028 SHALL keep the i2c_* address/data outputs stable from FETCH until the next FETCH.

Reset
REQ-029 SHALL, while rst=1, force state PWRUP; lut_index=0, i2c_slave_dev_addr=0, i2c_register_addr=0, i2c_write_data=0, i2c_write_req=0, done=0, error=0, and all counters 0; rst mid-transaction aborts immediately.

Verification (POWERUP_CYCLES=10, RESET_DELAY_CYCLES=20, MAX_RETRY=3)
REQ-030 SHALL cover: LUT {78_310311, 78_300882, FF_FFFFFF}, ack with no error -> writes 0x3103=0x11, then 0x3008=0x82, then 20-cycle gap, then done=1 with lut_index=2.
REQ-031 SHALL cover: entry 0 NACKed 3 times, then ACK -> 4 requests with identical address/data, then index advances to 1, error=0.
REQ-032 SHALL cover: entry 0 NACKed 4 times -> error=1, i2c_write_req=0, lut_index=0; a reinit pulse then clears error and PWRUP lasts 10 cycles.
REQ-033 SHALL cover: LUT with no sentinel (all 78_xxxxxx) -> 1024 writes, done=1 at lut_index=1023, no wrap.
REQ-034 SHALL cover: rst asserted in WAIT_ACK and a stray ack after release -> all outputs 0, and the first request appears 10 cycles after rst release plus the FETCH cycle.

Source files
------------

// File: rtl/lut_config_sequencer.sv
// Walks a configuration LUT and issues one I2C register write per entry,
// with power-up wait, per-entry NACK retry and a settle delay after one entry.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PWRUP    | idle wait after reset or reinit before the first fetch
// FETCH    | latch the LUT entry; 8'hFF device address ends the sequence
// REQ      | raise the write request for the latched entry
// WAIT_ACK | hold the request until the I2C master acknowledges
// DELAY    | settle wait after the designated entry
// DONE     | sequence complete, waits for reinit
// ERROR    | retries exhausted, waits for reinit
module lut_config_sequencer #(
    parameter logic [19:0] POWERUP_CYCLES     = 20'd1000000,
    parameter logic [9:0]  RESET_DELAY_INDEX  = 10'd1,
    parameter logic [19:0] RESET_DELAY_CYCLES = 20'd250000,
    parameter logic [1:0]  MAX_RETRY          = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reinit,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic [7:0]  i2c_slave_dev_addr,
    output logic [15:0] i2c_register_addr,
    output logic [7:0]  i2c_write_data,
    output logic        i2c_write_req,
    input  logic        i2c_write_req_ack,
    input  logic        i2c_error,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        PWRUP,
        FETCH,
        REQ,
        WAIT_ACK,
        DELAY,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [1:0]  retry;
    logic [1:0]  retry_nxt;
    logic [9:0]  index_nxt;
    logic        load_fields;
    logic        advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= PWRUP;
            cnt                <= 20'd0;
            retry              <= 2'd0;
            lut_index          <= 10'd0;
            i2c_slave_dev_addr <= 8'd0;
            i2c_register_addr  <= 16'd0;
            i2c_write_data     <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            lut_index <= index_nxt;
            if (load_fields) begin
                i2c_slave_dev_addr <= lut_data[31:24];
                i2c_register_addr  <= lut_data[23:8];
                i2c_write_data     <= lut_data[7:0];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retry_nxt   = retry;
        index_nxt   = lut_index;
        load_fields = 1'b0;
        advance     = 1'b0;

        case (state)
            PWRUP: begin
                if (cnt == POWERUP_CYCLES - 20'd1) begin
                    cnt_nxt   = 20'd0;
                    state_nxt = FETCH;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            FETCH: begin
                load_fields = 1'b1;
                retry_nxt   = 2'd0;
                state_nxt   = (lut_data[31:24] == 8'hFF) ? DONE : REQ;
            end
            REQ: begin
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i2c_write_req_ack) begin
                    if (!i2c_error) begin
                        if (lut_index == RESET_DELAY_INDEX) begin
                            cnt_nxt   = 20'd0;
                            state_nxt = DELAY;
                        end else begin
                            advance = 1'b1;
                        end
                    end else if (retry < MAX_RETRY) begin
                        retry_nxt = retry + 2'd1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = ERROR;
                    end
                end
            end
            DELAY: begin
                if (cnt == RESET_DELAY_CYCLES - 20'd1) begin
                    cnt_nxt = 20'd0;
                    advance = 1'b1;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            DONE, ERROR: begin
                if (reinit) begin
                    index_nxt = 10'd0;
                    cnt_nxt   = 20'd0;
                    state_nxt = PWRUP;
                end
            end
            default: begin
                state_nxt = PWRUP;
            end
        endcase

        // The last LUT slot finishes the sequence instead of wrapping to 0.
        if (advance) begin
            if (lut_index == 10'd1023) begin
                state_nxt = DONE;
            end else begin
                index_nxt = lut_index + 10'd1;
                state_nxt = FETCH;
            end
        end
    end

    assign i2c_write_req = (state == REQ) || (state == WAIT_ACK);
    assign done          = (state == DONE);
    assign error         = (state == ERROR);

endmodule
